// File: rtl/bitnet_pkg.sv
// rtl/bitnet_pkg.sv - shared ternary weight codes for the bitnet datapath blocks
package bitnet_pkg;

    typedef logic [1:0] ternary_t;

    localparam ternary_t W_ZERO = 2'b00;
    localparam ternary_t W_POS  = 2'b01;
    localparam ternary_t W_NEG  = 2'b11;
    localparam ternary_t W_RSVD = 2'b10;

    function automatic logic is_reserved(input ternary_t w);
        return w == W_RSVD;
    endfunction

endpackage

// File: rtl/ternary_dot_accum_if.sv
// rtl/ternary_dot_accum_if.sv - element stream in, dot-product result out
interface ternary_dot_accum_if
    import bitnet_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
);

    logic                         valid_in;
    logic signed [DATA_WIDTH-1:0] data_in;
    ternary_t                     weight_in;
    logic signed [ACC_WIDTH-1:0]  result_out;
    logic                         valid_out;
    logic                         sat_out;
    logic                         code_err_out;

    modport master (
        output valid_in, data_in, weight_in,
        input  result_out, valid_out, sat_out, code_err_out
    );

    modport slave (
        input  valid_in, data_in, weight_in,
        output result_out, valid_out, sat_out, code_err_out
    );

endinterface

// File: rtl/ternary_dot_accum.sv
// rtl/ternary_dot_accum.sv - ternary-weight dot product: decode, saturating accumulate, result register
module ternary_dot_accum
    import bitnet_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int VEC_LEN    = 64
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  ternary_t                     weight_in,
    output logic signed [ACC_WIDTH-1:0]  result_out,
    output logic                         valid_out,
    output logic                         sat_out,
    output logic                         code_err_out
);

    localparam int CNT_W = $clog2(VEC_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0] term_q, term_d;
    logic                        term_valid_q;
    logic                        term_last_q, term_last_d;
    logic                        code_err_q, code_err_d;

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        vsat_q, vsat_d;
    logic                        fresh_q, fresh_d;
    logic                        done_q, done_d;

    logic signed [ACC_WIDTH-1:0] result_q, result_d;
    logic                        sat_q, sat_d;
    logic                        valid_q;

    logic signed [ACC_WIDTH-1:0] data_ext;
    logic signed [ACC_WIDTH-1:0] base;
    logic                        prior_sat;
    logic        [ACC_WIDTH:0]   sum;

    // Negation happens at accumulator width so the most negative input negates exactly.
    assign data_ext = {{(ACC_WIDTH-DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};

    always_comb begin
        term_d      = '0;
        term_last_d = 1'b0;
        cnt_d       = cnt_q;
        code_err_d  = code_err_q;
        case (weight_in)
            W_POS:   term_d = data_ext;
            W_NEG:   term_d = -data_ext;
            default: term_d = '0;
        endcase
        if (valid_in) begin
            term_last_d = (cnt_q == CNT_LAST);
            cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            code_err_d  = code_err_q | is_reserved(weight_in);
        end
    end

    // After a last term the held accumulator is the finished result; the next term restarts from zero.
    assign base      = fresh_q ? '0 : acc_q;
    assign prior_sat = fresh_q ? 1'b0 : vsat_q;
    assign sum       = {base[ACC_WIDTH-1], base} + {term_q[ACC_WIDTH-1], term_q};

    always_comb begin
        acc_d   = acc_q;
        vsat_d  = vsat_q;
        fresh_d = fresh_q;
        done_d  = 1'b0;
        if (term_valid_q) begin
            acc_d  = base;
            vsat_d = prior_sat;
            if (!prior_sat) begin
                if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
                    acc_d  = sum[ACC_WIDTH] ? SAT_LO : SAT_HI;
                    vsat_d = 1'b1;
                end else begin
                    acc_d = sum[ACC_WIDTH-1:0];
                end
            end
            fresh_d = term_last_q;
            done_d  = term_last_q;
        end
    end

    always_comb begin
        result_d = result_q;
        sat_d    = sat_q;
        if (done_q) begin
            result_d = acc_q;
            sat_d    = vsat_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q        <= '0;
            term_q       <= '0;
            term_valid_q <= 1'b0;
            term_last_q  <= 1'b0;
            code_err_q   <= 1'b0;
            acc_q        <= '0;
            vsat_q       <= 1'b0;
            fresh_q      <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            sat_q        <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            term_q       <= term_d;
            term_valid_q <= valid_in;
            term_last_q  <= term_last_d;
            code_err_q   <= code_err_d;
            acc_q        <= acc_d;
            vsat_q       <= vsat_d;
            fresh_q      <= fresh_d;
            done_q       <= done_d;
            result_q     <= result_d;
            sat_q        <= sat_d;
            valid_q      <= done_q;
        end
    end

    assign result_out   = result_q;
    assign valid_out    = valid_q;
    assign sat_out      = sat_q;
    assign code_err_out = code_err_q;

endmodule
